// File: rtl/tdm_mux8x1_pkg.sv
// Shared constants and state encoding for the 8-lane TDM mux/demux pair.
// The far-end demux imports the same lane count and select width.
package tdm_mux8x1_pkg;

    localparam int                LANES     = 8;
    localparam int                SEL_W     = 3;
    localparam logic [SEL_W-1:0]  LAST_LANE = 3'd7;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_mux8x1_if.sv
// Parallel-word handshake plus tagged lane-sample output of the TDM mux.
// The producer side uses master; the mux itself uses slave.
interface tdm_mux8x1_if #(
    parameter int W = 1
);
    import tdm_mux8x1_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [LANES*W-1:0]   in_data;
    logic                 hold;
    logic [W-1:0]         dout;
    logic [SEL_W-1:0]     sel;
    logic                 dout_valid;
    logic                 frame_start;
    logic                 frame_done;
    logic                 busy;

    modport master (
        output in_valid, in_data, hold,
        input  in_ready, dout, sel, dout_valid, frame_start, frame_done, busy
    );

    modport slave (
        input  in_valid, in_data, hold,
        output in_ready, dout, sel, dout_valid, frame_start, frame_done, busy
    );

endinterface

// File: rtl/tdm_mux8x1.sv
// Time-division 8:1 serializer: takes one parallel word, emits lanes 0..7 one
// per cycle tagged with their lane select, back-to-back when a new word waits.
module tdm_mux8x1
    import tdm_mux8x1_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    tdm_mux8x1_if.slave  bus
);

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    cnt_q, cnt_d;
    logic [LANES*W-1:0]  buf_q, buf_d;
    logic [W-1:0]        dout_q, dout_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                dv_q, dv_d;
    logic                fs_q, fs_d;
    logic                fd_q, fd_d;
    logic                ready;

    // Acceptance opens in IDLE, or on the last lane when not stalled, so a
    // waiting word follows lane 7 with no bubble.
    assign ready = rst_n & ((state_q == IDLE) |
                            ((state_q == SHIFT) & (cnt_q == LAST_LANE) & ~bus.hold));

    always_comb begin
        // NOTE: every next-state value gets a default first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        dout_d  = dout_q;
        sel_d   = sel_q;
        dv_d    = 1'b0;
        fs_d    = 1'b0;
        fd_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    buf_d   = bus.in_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!bus.hold) begin
                    dout_d = buf_q[int'(cnt_q)*W +: W];
                    sel_d  = cnt_q;
                    dv_d   = 1'b1;
                    fs_d   = (cnt_q == '0);
                    fd_d   = (cnt_q == LAST_LANE);
                    if (cnt_q != LAST_LANE) begin
                        cnt_d = cnt_q + SEL_W'(1);
                    end else if (bus.in_valid) begin
                        buf_d = bus.in_data;
                        cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
            dout_q  <= '0;
            sel_q   <= '0;
            dv_q    <= 1'b0;
            fs_q    <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            dout_q  <= dout_d;
            sel_q   <= sel_d;
            dv_q    <= dv_d;
            fs_q    <= fs_d;
            fd_q    <= fd_d;
        end
    end

    assign bus.in_ready    = ready;
    assign bus.dout        = dout_q;
    assign bus.sel         = sel_q;
    assign bus.dout_valid  = dv_q;
    assign bus.frame_start = fs_q;
    assign bus.frame_done  = fd_q;
    assign bus.busy        = (state_q == SHIFT);

endmodule

// File: tb/tb_tdm_mux8x1.sv
// Scoreboard bench for tdm_mux8x1 (W=1): a lanes-remaining model predicts the
// handshake, and a monitor checks each tagged sample plus a far-end demux rebuild.
module tb_tdm_mux8x1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    tdm_mux8x1_if #(.W(1)) bus ();

    tdm_mux8x1 #(.W(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       d;
        logic [2:0] s;
        logic       fs;
        logic       fd;
    } sample_t;

    sample_t    sb[$];
    logic [7:0] words[$];
    int         rem = 0;
    logic       expect_dv = 1'b0;
    logic       last_dout = 1'b0;
    logic [2:0] last_sel = 3'd0;
    logic [7:0] demux = 8'h00;
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; called just after a rising edge.
    task automatic step(input logic v, input logic [7:0] d, input logic h, output logic xfer);
        logic exp_ready, emit;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.hold     = h;
        @(negedge clk);
        exp_ready = rst_n && (rem == 0 || (rem == 1 && !h));
        check("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_ready});
        check("busy", {31'd0, bus.busy}, {31'd0, rem != 0});
        xfer = v && exp_ready;
        emit = (rem != 0) && !h;
        if (xfer) begin
            for (int k = 0; k < 8; k++) begin
                sb.push_back('{d: d[k], s: 3'(k), fs: (k == 0), fd: (k == 7)});
            end
            words.push_back(d);
        end
        @(posedge clk);
        #1;
        if (emit) rem--;
        if (xfer) rem = 8;
        expect_dv = emit;
    endtask

    task automatic idle(input int n);
        logic x;
        for (int i = 0; i < n; i++) step(1'b0, $urandom(), 1'b0, x);
    endtask

    task automatic send(input logic [7:0] w);
        logic x;
        x = 1'b0;
        for (int i = 0; i < 20 && !x; i++) step(1'b1, w, 1'b0, x);
        check("send_accepted", {31'd0, x}, 32'd1);
    endtask

    task automatic run_until_rem(input int target);
        logic x;
        for (int i = 0; i < 20 && rem != target; i++) step(1'b0, 8'h00, 1'b0, x);
        check("reached_lane", rem, target);
    endtask

    // Asynchronous reset asserted between edges; model state is discarded.
    task automatic apply_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_dout", {31'd0, bus.dout}, 32'd0);
        check("rst_sel", {29'd0, bus.sel}, 32'd0);
        check("rst_dout_valid", {31'd0, bus.dout_valid}, 32'd0);
        check("rst_frame_start", {31'd0, bus.frame_start}, 32'd0);
        check("rst_frame_done", {31'd0, bus.frame_done}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        rem = 0;
        expect_dv = 1'b0;
        last_dout = 1'b0;
        last_sel = 3'd0;
        sb.delete();
        words.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: pops and compares whenever the DUT presents a sample.
    initial begin
        sample_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("dout_valid", {31'd0, bus.dout_valid}, {31'd0, expect_dv});
                if (bus.dout_valid) begin
                    if (sb.size() == 0) begin
                        check("unexpected_sample", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("dout", {31'd0, bus.dout}, {31'd0, e.d});
                        check("sel", {29'd0, bus.sel}, {29'd0, e.s});
                        check("frame_start", {31'd0, bus.frame_start}, {31'd0, e.fs});
                        check("frame_done", {31'd0, bus.frame_done}, {31'd0, e.fd});
                    end
                    demux[bus.sel] = bus.dout;
                    last_dout = bus.dout;
                    last_sel  = bus.sel;
                    if (bus.frame_done) begin
                        if (words.size() == 0) check("loopback_word_missing", 32'd1, 32'd0);
                        else check("demux_loopback", {24'd0, demux}, {24'd0, words.pop_front()});
                    end
                end else begin
                    check("dout_held", {31'd0, bus.dout}, {31'd0, last_dout});
                    check("sel_held", {29'd0, bus.sel}, {29'd0, last_sel});
                    check("frame_start_idle", {31'd0, bus.frame_start}, 32'd0);
                    check("frame_done_idle", {31'd0, bus.frame_done}, 32'd0);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic x;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.hold     = 1'b0;
        @(posedge clk);
        #1;
        apply_reset();

        // Single word: lanes 0,1,1,0,0,1,0,1.
        send(8'b1010_0110);
        idle(10);

        // Back-to-back words with in_valid held high.
        send(8'hFF);
        send(8'h00);
        idle(10);

        // Hold for 3 cycles after sel=3 is emitted.
        send(8'h5A);
        run_until_rem(4);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, x);
        idle(8);

        // Hold at the last lane while the next word waits.
        send(8'hC3);
        run_until_rem(1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h3C, 1'b1, x);
            check("no_xfer_under_hold", {31'd0, x}, 32'd0);
        end
        step(1'b1, 8'h3C, 1'b0, x);
        check("xfer_on_hold_release", {31'd0, x}, 32'd1);
        idle(10);

        // Async reset mid-frame after sel=2.
        send(8'h96);
        run_until_rem(5);
        apply_reset();
        idle(10);

        // Randomized traffic with random stalls.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom()), ($urandom_range(0, 4) == 0), x);
        end
        idle(12);

        check("scoreboard_drained", sb.size(), 32'd0);
        check("words_drained", words.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
